seq_divider: RTL

- Multi-cycle iterative restoring divider for the EX stage. Implements LEGv8 UDIV/SDIV, which the single-cycle ALU slice chain cannot compute.
- Performs the inverse of the ALU's add/subtract path: one trial subtraction per cycle (A + ~B + 1), shifting in quotient bits.
- Sits beside the ALU in EX. The hazard unit holds the pipeline while busy is high.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 123 ++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative EX-stage divider.
package seq_divider_pkg;

   localparam int DIV_WIDTH = 64;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX,
      DONE
   } state_t;

   function automatic int cnt_bits(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between EX control and the divider.
interface seq_divider_if
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder,
      input  div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder,
      output div_by_zero
   );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring step: shift in a dividend bit, trial-subtract divisor.
module div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_nxt,
   output logic             q_bit
);

   logic [WIDTH-1:0] low;
   logic [WIDTH:0]   sum;

   assign low = {rem[WIDTH-2:0], dvd_msb};

   // A + ~B + 1; the bit shifted out of rem is the trial's top bit
   assign sum = {1'b0, low}
              + {1'b0, ~divisor}
              + (WIDTH+1)'(1);

   assign q_bit   = rem[WIDTH-1] | sum[WIDTH];
   assign rem_nxt = q_bit ? sum[WIDTH-1:0] : low;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for UDIV/SDIV beside the EX-stage ALU.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic        clk,
   input  logic        reset_n,
   seq_divider_if.slave bus
);

   localparam int CW = cnt_bits(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [CW-1:0]    count;
   logic             neg_q;
   logic             neg_r;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rmd_q;
   logic             dbz_q;

   logic             sd;
   logic             ss;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH-1:0] rem_nxt;
   logic             q_bit;

   assign sd = bus.is_signed & bus.dividend[WIDTH-1];
   assign ss = bus.is_signed & bus.divisor[WIDTH-1];

   assign dvd_mag = sd ? -bus.dividend : bus.dividend;
   assign dsr_mag = ss ? -bus.divisor  : bus.divisor;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem     (rem),
      .dvd_msb (dvd[WIDTH-1]),
      .divisor (dsr),
      .rem_nxt (rem_nxt),
      .q_bit   (q_bit)
   );

   // dvd doubles as the quotient: dividend bits leave at the top
   // while quotient bits enter at the bottom
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         rem    <= '0;
         dvd    <= '0;
         dsr    <= '0;
         count  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         quo_q  <= '0;
         rmd_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  dvd   <= dvd_mag;
                  dsr   <= dsr_mag;
                  rem   <= '0;
                  count <= CW'(WIDTH-1);
                  neg_q <= sd ^ ss;
                  neg_r <= sd;
                  if (bus.divisor == '0) begin
                     quo_q  <= '0;
                     rmd_q  <= bus.dividend;
                     dbz_q  <= 1'b1;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     busy_q <= 1'b1;
                     state  <= RUN;
                  end
               end
            end
            RUN: begin
               rem <= rem_nxt;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               if (count == '0) begin
                  state <= FIX;
               end else begin
                  count <= count - CW'(1);
               end
            end
            FIX: begin
               quo_q  <= neg_q ? -dvd : dvd;
               rmd_q  <= neg_r ? -rem : rem;
               dbz_q  <= 1'b0;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dbz_q;

endmodule
